// File: rtl/pic_ack_sequencer_pkg.sv
// Shared types and helpers for the PIC acknowledge/priority logic.
package pic_pkg;

   // Acknowledge sequence states: waiting, INT raised, between INTA pulses.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK1 = 2'd2
   } pic_ack_state_t;

   typedef logic [2:0] pic_level_t;

   // Level reported when the request vanished before the first INTA.
   localparam pic_level_t PIC_SPURIOUS_LEVEL = 3'd7;

   // Reset value of the lowest-priority pointer: IR0 ranks highest.
   localparam pic_level_t PIC_RESET_LOWEST = 3'd7;

   // Rank of a level under the current rotation; 0 is the highest priority.
   function automatic pic_level_t pic_rank(input pic_level_t level,
                                           input pic_level_t lowest_prio);
      return level - lowest_prio - 3'd1;
   endfunction

endpackage

// File: rtl/pic_ack_sequencer_if.sv
// Bus between the CPU-side interface/request registers and the sequencer.
// The master side supplies requests, strobes and commands; the slave side
// is the sequencer, which returns INT, ISR, IRR clears and the vector.
interface pic_ack_sequencer_if #(
   parameter int VECTOR_BASE_W = 5
);
   logic [7:0]               irr;
   logic [7:0]               imr;
   logic                     inta;
   logic                     eoi_cmd;
   logic                     eoi_specific;
   logic [2:0]               eoi_level;
   logic                     rotate_on_eoi;
   logic                     auto_eoi;
   logic [VECTOR_BASE_W-1:0] vector_base;
   logic                     int_out;
   logic [7:0]               isr;
   logic [7:0]               clear_irr;
   logic [VECTOR_BASE_W+2:0] data_out;
   logic                     data_valid;

   modport master (
      output irr, imr, inta, eoi_cmd, eoi_specific, eoi_level,
             rotate_on_eoi, auto_eoi, vector_base,
      input  int_out, isr, clear_irr, data_out, data_valid
   );

   modport slave (
      input  irr, imr, inta, eoi_cmd, eoi_specific, eoi_level,
             rotate_on_eoi, auto_eoi, vector_base,
      output int_out, isr, clear_irr, data_out, data_valid
   );
endinterface

// File: rtl/pic_ack_sequencer_resolver.sv
// Combinational priority resolver: finds the best-ranked set bit of an
// 8-bit vector under a rotatable priority order.
import pic_pkg::*;

module pic_priority_resolver (
   input  logic [7:0] vec_i,
   input  pic_level_t lowest_prio_i,
   output logic       any_o,
   output pic_level_t level_o,
   output pic_level_t rank_o
);

   // Scan all levels and keep the set bit with the smallest rank.
   always_comb begin
      any_o   = 1'b0;
      level_o = '0;
      rank_o  = '1;
      for (int i = 0; i < 8; i++) begin
         if (vec_i[i] &&
             (!any_o || (pic_rank(pic_level_t'(i), lowest_prio_i) < rank_o))) begin
            any_o   = 1'b1;
            level_o = pic_level_t'(i);
            rank_o  = pic_rank(pic_level_t'(i), lowest_prio_i);
         end
      end
   end

endmodule

// File: rtl/pic_ack_sequencer.sv
// Interrupt acknowledge and priority controller: raises INT for the best
// unmasked request that outranks the in-service set, runs the two-pulse
// INTA sequence, owns the ISR and applies EOI commands with rotation.
import pic_pkg::*;

module pic_ack_sequencer #(
   parameter int VECTOR_BASE_W = 5
) (
   input logic                clock,
   input logic                reset,
   pic_ack_sequencer_if.slave bus
);

   pic_ack_state_t           state_q, state_d;
   pic_level_t               lowest_q, lowest_d;
   pic_level_t               level_q, level_d;
   logic                     spur_q, spur_d;
   logic [7:0]               isr_q, isr_d;
   logic [7:0]               clear_irr_q, clear_irr_d;
   logic [VECTOR_BASE_W+2:0] data_out_q, data_out_d;
   logic                     data_valid_q, data_valid_d;
   logic                     int_out_q, int_out_d;

   logic [7:0] cand;
   logic       cand_any, isr_any;
   pic_level_t cand_level, cand_rank, isr_level, isr_rank;
   logic       req_valid;
   pic_level_t eoi_tgt;
   logic       eoi_hit;

   assign cand = bus.irr & ~bus.imr;

   pic_priority_resolver u_cand (
      .vec_i         (cand),
      .lowest_prio_i (lowest_q),
      .any_o         (cand_any),
      .level_o       (cand_level),
      .rank_o        (cand_rank)
   );

   pic_priority_resolver u_isr (
      .vec_i         (isr_q),
      .lowest_prio_i (lowest_q),
      .any_o         (isr_any),
      .level_o       (isr_level),
      .rank_o        (isr_rank)
   );

   // A candidate must strictly outrank everything in service (nesting).
   assign req_valid = cand_any && (!isr_any || (cand_rank < isr_rank));

   // State and registered outputs; reset aborts any sequence in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         lowest_q     <= PIC_RESET_LOWEST;
         level_q      <= '0;
         spur_q       <= 1'b0;
         isr_q        <= '0;
         clear_irr_q  <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         int_out_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lowest_q     <= lowest_d;
         level_q      <= level_d;
         spur_q       <= spur_d;
         isr_q        <= isr_d;
         clear_irr_q  <= clear_irr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         int_out_q    <= int_out_d;
      end
   end

   // Next state: INTA is only meaningful once INT has been raised.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid) state_d = REQ;
         REQ:     if (bus.inta)  state_d = ACK1;
         ACK1:    if (bus.inta)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values. EOI acts on the pre-INTA ISR first, so
   // a set from the first INTA on the same bit overrides the clear.
   always_comb begin
      lowest_d     = lowest_q;
      level_d      = level_q;
      spur_d       = spur_q;
      isr_d        = isr_q;
      clear_irr_d  = '0;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      int_out_d    = (state_q == REQ) && !bus.inta;
      eoi_tgt      = isr_level;
      eoi_hit      = 1'b0;

      if (bus.eoi_cmd) begin
         if (bus.eoi_specific) begin
            eoi_tgt = bus.eoi_level;
            eoi_hit = isr_q[bus.eoi_level];
         end else begin
            eoi_tgt = isr_level;
            eoi_hit = isr_any;
         end
         if (eoi_hit) begin
            isr_d[eoi_tgt] = 1'b0;
            if (bus.rotate_on_eoi) lowest_d = eoi_tgt;
         end
      end

      if ((state_q == REQ) && bus.inta) begin
         if (req_valid) begin
            level_d                 = cand_level;
            spur_d                  = 1'b0;
            isr_d[cand_level]       = 1'b1;
            clear_irr_d[cand_level] = 1'b1;
         end else begin
            level_d = PIC_SPURIOUS_LEVEL;
            spur_d  = 1'b1;
         end
      end

      if ((state_q == ACK1) && bus.inta) begin
         data_out_d   = {bus.vector_base, level_q};
         data_valid_d = 1'b1;
         if (bus.auto_eoi && !spur_q) begin
            isr_d[level_q] = 1'b0;
            if (bus.rotate_on_eoi) lowest_d = level_q;
         end
      end
   end

   assign bus.int_out    = int_out_q;
   assign bus.isr        = isr_q;
   assign bus.clear_irr  = clear_irr_q;
   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
module tb_pic_ack_sequencer;

   typedef struct {
      logic [7:0] data;
      logic [7:0] isr;
   } exp_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   pic_ack_sequencer_if #(.VECTOR_BASE_W(5)) bus ();

   pic_ack_sequencer #(.VECTOR_BASE_W(5)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_vec(input logic [7:0] data, input logic [7:0] isr);
      exp_t e;
      e.data = data;
      e.isr  = isr;
      sb.push_back(e);
   endtask

   task automatic pulse_inta();
      bus.inta = 1'b1;
      tick();
      bus.inta = 1'b0;
   endtask

   task automatic eoi(input logic specific, input logic [2:0] lvl, input logic rot);
      bus.eoi_cmd       = 1'b1;
      bus.eoi_specific  = specific;
      bus.eoi_level     = lvl;
      bus.rotate_on_eoi = rot;
      tick();
      bus.eoi_cmd       = 1'b0;
      bus.eoi_specific  = 1'b0;
      bus.rotate_on_eoi = 1'b0;
   endtask

   // Scoreboard monitor: every vector the DUT presents must match the queue head.
   always @(negedge clk) begin
      if (bus.data_valid === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL vector_unexpected: got data=%0h isr=%0h, expected none", bus.data_out, bus.isr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.data_out !== e.data || bus.isr !== e.isr) begin
               n_bad++;
               $display("FAIL vector: got data=%0h isr=%0h, expected data=%0h isr=%0h",
                        bus.data_out, bus.isr, e.data, e.isr);
            end
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.irr = 8'h00;
      bus.imr = 8'h00;
      bus.inta = 1'b0;
      bus.eoi_cmd = 1'b0;
      bus.eoi_specific = 1'b0;
      bus.eoi_level = 3'd0;
      bus.rotate_on_eoi = 1'b0;
      bus.auto_eoi = 1'b0;
      bus.vector_base = 5'h08;
      tick();
      tick();
      chk("rst_int_out", bus.int_out, 0);
      chk("rst_isr", bus.isr, 0);
      chk("rst_clear_irr", bus.clear_irr, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_data_valid", bus.data_valid, 0);
      rst = 1'b0;
      tick();

      // Single request on IR3
      bus.irr = 8'h08;
      tick();
      chk("single_int_early", bus.int_out, 0);
      tick();
      chk("single_int_rise", bus.int_out, 1);
      pulse_inta();
      chk("single_isr", bus.isr, 8'h08);
      chk("single_clear_irr", bus.clear_irr, 8'h08);
      chk("single_int_fall", bus.int_out, 0);
      bus.irr = 8'h00;
      expect_vec(8'h43, 8'h08);
      pulse_inta();
      tick();
      chk("single_valid_one_cycle", bus.data_valid, 0);
      eoi(1'b0, 3'd0, 1'b0);
      chk("single_eoi", bus.isr, 8'h00);

      // Priority: IR2 beats IR5, then IR0 nests over IR2
      bus.irr = 8'h24;
      tick();
      tick();
      chk("prio_int", bus.int_out, 1);
      pulse_inta();
      chk("prio_isr", bus.isr, 8'h04);
      chk("prio_clear_irr", bus.clear_irr, 8'h04);
      bus.irr = 8'h20;
      expect_vec(8'h42, 8'h04);
      pulse_inta();
      tick();
      tick();
      chk("prio_ir5_blocked", bus.int_out, 0);
      bus.irr = 8'h21;
      tick();
      tick();
      chk("nest_int", bus.int_out, 1);
      pulse_inta();
      chk("nest_clear_irr", bus.clear_irr, 8'h01);
      bus.irr = 8'h00;
      expect_vec(8'h40, 8'h05);
      pulse_inta();
      chk("nest_isr", bus.isr, 8'h05);
      eoi(1'b0, 3'd0, 1'b0);
      chk("nest_eoi1", bus.isr, 8'h04);
      eoi(1'b0, 3'd0, 1'b0);
      chk("nest_eoi2", bus.isr, 8'h00);
      eoi(1'b0, 3'd0, 1'b0);
      chk("eoi_empty", bus.isr, 8'h00);

      // Masked request, then a spurious acknowledge
      bus.irr = 8'h10;
      bus.imr = 8'h10;
      tick();
      tick();
      tick();
      chk("mask_int", bus.int_out, 0);
      bus.imr = 8'h00;
      tick();
      tick();
      chk("unmask_int", bus.int_out, 1);
      bus.irr = 8'h00;
      tick();
      chk("withdrawn_int_held", bus.int_out, 1);
      pulse_inta();
      chk("spur_isr", bus.isr, 8'h00);
      chk("spur_clear_irr", bus.clear_irr, 8'h00);
      expect_vec(8'h47, 8'h00);
      pulse_inta();
      tick();

      // Build isr=0x06, non-specific then specific EOI with rotation
      bus.irr = 8'h04;
      tick();
      tick();
      pulse_inta();
      bus.irr = 8'h00;
      expect_vec(8'h42, 8'h04);
      pulse_inta();
      bus.irr = 8'h02;
      tick();
      tick();
      chk("nest2_int", bus.int_out, 1);
      pulse_inta();
      chk("nest2_isr", bus.isr, 8'h06);
      bus.irr = 8'h00;
      expect_vec(8'h41, 8'h06);
      pulse_inta();
      eoi(1'b0, 3'd0, 1'b0);
      chk("ns_eoi", bus.isr, 8'h04);
      eoi(1'b1, 3'd2, 1'b1);
      chk("spec_eoi_rot", bus.isr, 8'h00);
      bus.irr = 8'h09;
      tick();
      tick();
      pulse_inta();
      chk("rot_ir3_wins_isr", bus.isr, 8'h08);
      chk("rot_ir3_wins_clr", bus.clear_irr, 8'h08);
      bus.irr = 8'h01;
      expect_vec(8'h43, 8'h08);
      pulse_inta();
      tick();
      tick();
      chk("rot_ir0_below_ir3", bus.int_out, 0);
      bus.irr = 8'h00;
      eoi(1'b1, 3'd3, 1'b0);
      chk("spec_eoi3", bus.isr, 8'h00);

      // Auto-EOI: ISR already clear in the vector cycle
      bus.auto_eoi = 1'b1;
      bus.irr = 8'h10;
      tick();
      tick();
      pulse_inta();
      chk("aeoi_isr_set", bus.isr, 8'h10);
      bus.irr = 8'h00;
      expect_vec(8'h44, 8'h00);
      pulse_inta();
      bus.auto_eoi = 1'b0;
      tick();
      chk("aeoi_isr_after", bus.isr, 8'h00);

      // Specific EOI colliding with the first INTA for the same level
      bus.irr = 8'h10;
      tick();
      tick();
      bus.eoi_cmd = 1'b1;
      bus.eoi_specific = 1'b1;
      bus.eoi_level = 3'd4;
      pulse_inta();
      bus.eoi_cmd = 1'b0;
      bus.eoi_specific = 1'b0;
      chk("collide_isr", bus.isr, 8'h10);
      bus.irr = 8'h00;
      expect_vec(8'h44, 8'h10);
      pulse_inta();
      eoi(1'b0, 3'd0, 1'b0);
      chk("collide_eoi", bus.isr, 8'h00);

      // Reset while waiting for the second INTA
      bus.irr = 8'h10;
      tick();
      tick();
      pulse_inta();
      chk("rstseq_isr", bus.isr, 8'h10);
      bus.irr = 8'h00;
      rst = 1'b1;
      tick();
      chk("rstseq_int_out", bus.int_out, 0);
      chk("rstseq_isr_clr", bus.isr, 0);
      chk("rstseq_clear_irr", bus.clear_irr, 0);
      chk("rstseq_data_out", bus.data_out, 0);
      chk("rstseq_data_valid", bus.data_valid, 0);
      rst = 1'b0;
      pulse_inta();
      chk("rstseq_no_vector", bus.data_valid, 0);
      tick();
      tick();

      chk("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Interrupt acknowledge and priority controller for the 8259-compatible PIC. It resolves unmasked pending requests against the in-service set under a rotatable priority order and raises INT. It runs the two-pulse INTA sequence, owns the in-service register (ISR), and applies specific and non-specific EOI commands. It sits between the request/mask registers and the CPU-side bus interface, which supplies synchronised INTA strobes and decoded OCW2 commands.

## Interface
- `VECTOR_BASE_W`: default 5. Width of the vector base field (ICW2 T7..T3).
- `clock`: in, 1. Single system clock; all state on the rising edge.
- `reset`: in, 1. Asynchronous, active-high. Clears all state.
- `irr`: in, 8. Pending requests (IRQ0..IRQ7); held until `clear_irr`.
- `imr`: in, 8. Mask; 1 = masked.
- `inta`: in, 1. One-cycle strobe per CPU INTA pulse, already synchronised.
- `eoi_cmd`: in, 1. One-cycle EOI command strobe.
- `eoi_specific`: in, 1. 1 = specific EOI using `eoi_level`; 0 = non-specific.
- `eoi_level`: in, 3. Level for a specific EOI.
- `rotate_on_eoi`: in, 1. The cleared level becomes lowest priority.
- `auto_eoi`: in, 1. Clear the ISR bit at the end of the second INTA.
- `vector_base`: in, VECTOR_BASE_W. Upper vector bits.
- `int_out`: out, 1. Interrupt request to CPU.
- `isr`: out, 8. In-service register.
- `clear_irr`: out, 8. One-hot, one-cycle pulse that clears the acknowledged IRR bit.
- `data_out`: out, 8. Interrupt vector `{vector_base, level}`.
- `data_valid`: out, 1. One-cycle qualifier for `data_out`.

## Operation
- Candidates: `irr & ~imr`. Priority of level i is `(i - lowest_prio - 1) mod 8`; 0 is highest.
- `lowest_prio` is a 3-bit pointer, reset to 7, so IR0 has highest priority.
- A request is valid when the highest-priority candidate ranks strictly above the highest-priority ISR bit, or when ISR is empty.
- State machine `IDLE`, `REQ`, `ACK1`:
  - `IDLE`: a valid request moves to `REQ`. `inta` in `IDLE` is ignored.
  - `REQ`: `int_out`=1. On `inta`, latch the winning level L, set `isr[L]`, pulse `clear_irr[L]`, and go to `ACK1`.
  - `REQ`, spurious case: if no valid request exists at the `inta` cycle, latch L=7, leave ISR and IRR untouched, and go to `ACK1`.
  - `ACK1`: `int_out`=0. On `inta`, drive `data_out={vector_base,L}` with `data_valid`=1. If `auto_eoi` is set and the acknowledge was not spurious, clear `isr[L]` (and rotate if `rotate_on_eoi`). Then go to `IDLE`.
- A request withdrawn while in `REQ` keeps `int_out` high until `inta`, which then follows the spurious path.
- EOI, applied in any state:
  - Non-specific: clears the highest-priority set ISR bit. No effect if ISR is empty.
  - Specific: clears `isr[eoi_level]`.
  - When `rotate_on_eoi` is set and a bit is cleared, `lowest_prio` takes the cleared level. No rotation if nothing is cleared.
- EOI in the same cycle as the first `inta`: EOI is evaluated on the pre-`inta` ISR, then the set is applied. If both target the same bit, the set wins.
- A new request at a higher level than an in-service one causes nesting: `int_out` reasserts while a lower ISR bit remains set.

## Timing
- Reset values: `int_out`=0, `isr`=0, `clear_irr`=0, `data_out`=0, `data_valid`=0, state `IDLE`, `lowest_prio`=7.
- All outputs are registered.
- `int_out` rises 2 cycles after a valid request appears: one cycle `IDLE→REQ`, one cycle output register.
- `isr[L]` and `clear_irr[L]` are visible the cycle after the first `inta`.
- `int_out` falls the cycle after the first `inta`.
- `data_out` and `data_valid` are valid the cycle after the second `inta`, for exactly one cycle.
- An auto-EOI clear is visible in that same cycle.
- Minimum spacing between `inta` strobes is 1 cycle. Back-to-back strobes are legal.
- Asserting `reset` mid-sequence aborts the sequence: no `data_valid`, and ISR is cleared.

## Structure
- Shared package `pic_pkg` holds:
  - the state enum `pic_ack_state_t`;
  - the `pic_level_t` (3-bit) typedef;
  - the constant `PIC_SPURIOUS_LEVEL = 3'd7`;
  - the rank function `pic_rank(level, lowest_prio)`.
- Sub-module `pic_priority_resolver` (combinational):
  - inputs: 8-bit vector and `lowest_prio`;
  - outputs: `any`, the winning level, and its rank.
  - It is instantiated twice: once for candidates, once for ISR (non-specific EOI target and nesting compare).

## Test plan
- Single request: `irr=0x08`, `imr=0`, `vector_base=5'h08`.
  - `int_out` rises after 2 cycles.
  - First `inta` gives `isr=0x08` and `clear_irr=0x08`.
  - Second `inta` gives `data_out=0x43` and `data_valid` for one cycle.
- Priority and nesting:
  - `irr=0x24` gives IR2 serviced first.
  - With `isr=0x04`, a new `irr=0x01` reasserts `int_out`, and after two `inta` the result is `isr=0x05`.
- Mask and spurious:
  - `irr=0x10` with `imr=0x10` keeps `int_out` at 0.
  - Drop `irr` after `int_out` rises, then two `inta`: `data_out={base,3'd7}` and `isr` unchanged.
- EOI and rotation:
  - Start with `isr=0x06`. A non-specific EOI clears bit 1, giving `isr=0x04`.
  - A specific EOI at level 2 with `rotate_on_eoi`=1 gives `isr=0`, `lowest_prio=2`, and IR3 becomes highest priority.
- Auto-EOI and collisions:
  - With `auto_eoi`=1, `isr` is 0 in the `data_valid` cycle.
  - A specific EOI for L in the same cycle as the first `inta` for L leaves `isr[L]`=1.
- Reset during `ACK1`: all outputs are 0 on the next cycle, and no `data_valid` is produced.
